// File: rtl/sap_clock_gen_if.sv
// sap_clock_gen_if: control inputs and SAP clock outputs of the SAP-U clock module.
interface sap_clock_gen_if;
  logic i_manual;
  logic i_step_btn;
  logic i_halt;
  logic o_sap_clk;
  logic o_not_sap_clk;
  logic o_clk_en;
  logic o_halted;
  modport master (output i_manual, i_step_btn, i_halt, input o_sap_clk, o_not_sap_clk, o_clk_en, o_halted);
  modport slave (input i_manual, i_step_btn, i_halt, output o_sap_clk, o_not_sap_clk, o_clk_en, o_halted);
endinterface

// File: rtl/sap_clock_gen.sv
// sap_clock_gen: SAP-U clock with auto divide, debounced manual step and halt.
module sap_clock_gen #(
  parameter int HALF_PERIOD     = 25000,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input logic clk,
  input logic rst,
  sap_clock_gen_if.slave bus
);
  typedef enum logic [1:0] {LOW, HIGH, HALTED} state_t;
  localparam logic [CNT_WIDTH-1:0] HP_LAST = CNT_WIDTH'(HALF_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  state_t r_state;
  logic [CNT_WIDTH-1:0] r_cnt, r_db_cnt;
  logic [1:0] r_man_s, r_btn_s;
  logic r_btn_lvl, r_mode, r_sap, r_not_sap, r_en, r_halted;
  logic w_man, w_btn, w_db_done, w_step, w_low_entry, w_manual, w_ph_end;
  assign w_man       = r_man_s[1];
  assign w_btn       = r_btn_s[1];
  assign w_db_done   = (w_btn != r_btn_lvl) && (r_db_cnt == DB_LAST);
  assign w_step      = w_db_done && w_btn;
  assign w_low_entry = (r_state == LOW) && (r_cnt == '0);
  // the mode sampled at LOW entry applies in that same cycle
  assign w_manual    = w_low_entry ? w_man : r_mode;
  assign w_ph_end    = r_cnt == HP_LAST;
  assign bus.o_sap_clk     = r_sap;
  assign bus.o_not_sap_clk = r_not_sap;
  assign bus.o_clk_en      = r_en;
  assign bus.o_halted      = r_halted;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOW;
      r_cnt     <= '0;
      r_db_cnt  <= '0;
      r_man_s   <= '0;
      r_btn_s   <= '0;
      r_btn_lvl <= 1'b0;
      r_mode    <= 1'b0;
      r_sap     <= 1'b0;
      r_not_sap <= 1'b1;
      r_en      <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_man_s  <= {r_man_s[0], bus.i_manual};
      r_btn_s  <= {r_btn_s[0], bus.i_step_btn};
      r_db_cnt <= (w_btn == r_btn_lvl || w_db_done) ? '0 : r_db_cnt + 1'b1;
      if (w_db_done) r_btn_lvl <= w_btn;
      if (w_low_entry) r_mode <= w_man;
      r_en <= 1'b0;
      case (r_state)
        LOW:
          if (bus.i_halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
            r_cnt    <= '0;
          end else if (w_manual ? w_step : w_ph_end) begin
            r_state   <= HIGH;
            r_sap     <= 1'b1;
            r_not_sap <= 1'b0;
            r_en      <= 1'b1;
            r_cnt     <= '0;
          end else if (!w_manual) begin
            r_cnt <= r_cnt + 1'b1;
          end
        HIGH:
          if (w_ph_end) begin
            r_state   <= LOW;
            r_sap     <= 1'b0;
            r_not_sap <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        HALTED:
          if (!bus.i_halt) begin
            r_state  <= LOW;
            r_halted <= 1'b0;
            r_cnt    <= '0;
          end
        default: r_state <= LOW;
      endcase
    end
  end
endmodule
